// File: rtl/bug_motion_scheduler.sv
// Moves up to NUM_BUGS sprites clockwise around a rectangular path using one
// shared step engine; a prescaled tick starts a round-robin pass, one bug per clock.
module bug_motion_scheduler #(
    parameter int NUM_BUGS  = 4,
    parameter int TICK_DIV  = 40000,
    parameter int SPAWN_GAP = 64,
    parameter int X_MIN     = 200,
    parameter int X_MAX     = 547,
    parameter int Y_MIN     = 200,
    parameter int Y_MAX     = 446
) (
    input  logic                     pclk,
    input  logic                     rst,
    input  logic                     start,
    input  logic [NUM_BUGS-1:0]      kill,
    output logic [12*NUM_BUGS-1:0]   xpos,
    output logic [12*NUM_BUGS-1:0]   ypos,
    output logic [2*NUM_BUGS-1:0]    rotation,
    output logic [NUM_BUGS-1:0]      active,
    output logic                     busy,
    output logic                     lap_done,
    output logic                     all_clear
);
    localparam int PS_W  = $clog2(TICK_DIV);
    localparam int NS_W  = $clog2(NUM_BUGS + 1);
    localparam int IDX_W = (NUM_BUGS > 1) ? $clog2(NUM_BUGS) : 1;
    localparam int GAP_W = (SPAWN_GAP > 1) ? $clog2(SPAWN_GAP) : 1;

    localparam logic [PS_W-1:0]  PS_LAST   = PS_W'(TICK_DIV - 1);
    localparam logic [NS_W-1:0]  NS_ALL    = NS_W'(NUM_BUGS);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(NUM_BUGS - 1);
    localparam logic [GAP_W-1:0] GAP_RELOAD = GAP_W'(SPAWN_GAP - 1);
    localparam logic [11:0]      X_LO = 12'(X_MIN);
    localparam logic [11:0]      X_HI = 12'(X_MAX);
    localparam logic [11:0]      Y_LO = 12'(Y_MIN);
    localparam logic [11:0]      Y_HI = 12'(Y_MAX);

    typedef enum logic [1:0] {S_IDLE, S_WAIT_TICK, S_UPDATE, S_CHECK} state_t;

    state_t             state_reg;
    logic [PS_W-1:0]    prescaler_reg;
    logic [NS_W-1:0]    next_spawn_reg;
    logic [GAP_W-1:0]   gap_cnt_reg;
    logic [IDX_W-1:0]   idx_reg;
    logic               spawned_reg;
    logic [IDX_W-1:0]   spawned_idx_reg;
    logic [NUM_BUGS-1:0] active_reg;
    logic               busy_reg;
    logic               lap_done_reg;
    logic               all_clear_reg;
    logic [11:0]        x_reg   [NUM_BUGS];
    logic [11:0]        y_reg   [NUM_BUGS];
    logic [1:0]         rot_reg [NUM_BUGS];

    logic               tick;
    logic [IDX_W-1:0]   spawn_idx;
    logic               step_en;
    logic [11:0]        cur_x, cur_y, step_x, step_y;
    logic [1:0]         cur_rot, step_rot;
    logic               step_lap;

    assign tick      = (prescaler_reg == PS_LAST);
    assign spawn_idx = next_spawn_reg[IDX_W-1:0];

    // Shared step engine: evaluates the bug selected by idx_reg on its current values.
    always_comb begin
        cur_x    = x_reg[idx_reg];
        cur_y    = y_reg[idx_reg];
        cur_rot  = rot_reg[idx_reg];
        step_x   = cur_x;
        step_y   = cur_y;
        step_rot = cur_rot;
        step_lap = 1'b0;
        step_en  = active_reg[idx_reg] && !kill[idx_reg]
                   && !(spawned_reg && (spawned_idx_reg == idx_reg));
        case (cur_rot)
            2'd3: if (cur_x < X_HI) step_x = cur_x + 12'd1; else step_rot = 2'd2;
            2'd2: if (cur_y < Y_HI) step_y = cur_y + 12'd1; else step_rot = 2'd1;
            2'd1: if (cur_x > X_LO) step_x = cur_x - 12'd1; else step_rot = 2'd0;
            default: begin
                if (cur_y > Y_LO) begin
                    step_y = cur_y - 12'd1;
                end else begin
                    step_rot = 2'd3;
                    step_lap = 1'b1;
                end
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (rst) begin
            state_reg       <= S_IDLE;
            prescaler_reg   <= '0;
            next_spawn_reg  <= '0;
            gap_cnt_reg     <= '0;
            idx_reg         <= '0;
            spawned_reg     <= 1'b0;
            spawned_idx_reg <= '0;
            active_reg      <= '0;
            busy_reg        <= 1'b0;
            lap_done_reg    <= 1'b0;
            all_clear_reg   <= 1'b0;
            for (int i = 0; i < NUM_BUGS; i++) begin
                x_reg[i]   <= X_LO;
                y_reg[i]   <= Y_LO;
                rot_reg[i] <= 2'd3;
            end
        end else begin
            lap_done_reg  <= 1'b0;
            all_clear_reg <= 1'b0;
            // Kill is sampled every cycle; a spawn written below overrides it for one cycle.
            active_reg    <= active_reg & ~kill;
            if (state_reg == S_IDLE) begin
                prescaler_reg <= '0;
            end else begin
                prescaler_reg <= tick ? '0 : prescaler_reg + 1'b1;
            end

            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg      <= S_WAIT_TICK;
                        busy_reg       <= 1'b1;
                        next_spawn_reg <= '0;
                        gap_cnt_reg    <= '0;
                        spawned_reg    <= 1'b0;
                    end
                end
                S_WAIT_TICK: begin
                    if (tick) begin
                        spawned_reg <= 1'b0;
                        if ((next_spawn_reg < NS_ALL) && (gap_cnt_reg == '0)) begin
                            active_reg[spawn_idx] <= 1'b1;
                            x_reg[spawn_idx]      <= X_LO;
                            y_reg[spawn_idx]      <= Y_LO;
                            rot_reg[spawn_idx]    <= 2'd3;
                            next_spawn_reg        <= next_spawn_reg + 1'b1;
                            gap_cnt_reg           <= GAP_RELOAD;
                            spawned_reg           <= 1'b1;
                            spawned_idx_reg       <= spawn_idx;
                        end else if (gap_cnt_reg != '0) begin
                            gap_cnt_reg <= gap_cnt_reg - 1'b1;
                        end
                        idx_reg   <= '0;
                        state_reg <= S_UPDATE;
                    end
                end
                S_UPDATE: begin
                    if (step_en) begin
                        x_reg[idx_reg]   <= step_x;
                        y_reg[idx_reg]   <= step_y;
                        rot_reg[idx_reg] <= step_rot;
                        lap_done_reg     <= step_lap;
                    end
                    if (idx_reg == IDX_LAST) begin
                        state_reg <= S_CHECK;
                    end else begin
                        idx_reg <= idx_reg + 1'b1;
                    end
                end
                default: begin
                    if ((next_spawn_reg == NS_ALL) && (active_reg == '0)) begin
                        state_reg     <= S_IDLE;
                        busy_reg      <= 1'b0;
                        all_clear_reg <= 1'b1;
                    end else begin
                        state_reg <= S_WAIT_TICK;
                    end
                end
            endcase
        end
    end

    for (genvar gi = 0; gi < NUM_BUGS; gi++) begin : g_flat
        assign xpos[12*gi +: 12]   = x_reg[gi];
        assign ypos[12*gi +: 12]   = y_reg[gi];
        assign rotation[2*gi +: 2] = rot_reg[gi];
    end

    assign active    = active_reg;
    assign busy      = busy_reg;
    assign lap_done  = lap_done_reg;
    assign all_clear = all_clear_reg;
endmodule

// File: tb/tb_bug_motion_scheduler.sv
// Directed bench for bug_motion_scheduler: 2 bugs on a 10..13 x 20..22 path, tick every 8 clocks.
module tb_bug_motion_scheduler;
    localparam int NB = 2;

    logic pclk = 1'b0;
    logic rst = 1'b1;
    logic start = 1'b0;
    logic [NB-1:0] kill = '0;
    logic [12*NB-1:0] xpos, ypos;
    logic [2*NB-1:0] rotation;
    logic [NB-1:0] active;
    logic busy, lap_done, all_clear;

    int vectors = 0;
    int miscompares = 0;
    int cyc = 0;
    int lap_cnt = 0;
    int ac_cnt = 0;
    int busy_drops = 0;

    always #5 pclk = ~pclk;

    bug_motion_scheduler #(
        .NUM_BUGS(NB), .TICK_DIV(8), .SPAWN_GAP(3),
        .X_MIN(10), .X_MAX(13), .Y_MIN(20), .Y_MAX(22)
    ) dut (
        .pclk(pclk), .rst(rst), .start(start), .kill(kill),
        .xpos(xpos), .ypos(ypos), .rotation(rotation), .active(active),
        .busy(busy), .lap_done(lap_done), .all_clear(all_clear)
    );

    function automatic int bx(input int i); return int'(xpos[12*i +: 12]); endfunction
    function automatic int by(input int i); return int'(ypos[12*i +: 12]); endfunction
    function automatic int br(input int i); return int'(rotation[2*i +: 2]); endfunction

    // Advance to 1 time unit after edge k (edges counted from the one that samples start).
    task automatic goto(input int k);
        while (cyc < k) begin
            @(posedge pclk);
            #1;
            cyc++;
            if (lap_done === 1'b1) lap_cnt++;
            if (all_clear === 1'b1) ac_cnt++;
            if (busy !== 1'b1) busy_drops++;
        end
    endtask

    task automatic begin_round(input logic hold);
        start = 1'b1;
        @(posedge pclk);
        #1;
        cyc = 0; lap_cnt = 0; ac_cnt = 0; busy_drops = 0;
        if (!hold) start = 1'b0;
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(posedge pclk);
        #1;
        rst = 1'b0;
        cyc = 0; lap_cnt = 0; ac_cnt = 0; busy_drops = 0;
        goto(20);
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL reset_active: got %b want 00", active); end
        vectors++; if (xpos !== {12'd10, 12'd10}) begin miscompares++; $display("FAIL reset_xpos: got %h want 00a00a", xpos); end
        vectors++; if (ypos !== {12'd20, 12'd20}) begin miscompares++; $display("FAIL reset_ypos: got %h want 014014", ypos); end
        vectors++; if (rotation !== 4'b1111) begin miscompares++; $display("FAIL reset_rotation: got %b want 1111", rotation); end
        vectors++; if (lap_cnt != 0 || ac_cnt != 0) begin miscompares++; $display("FAIL reset_pulses: got lap=%0d clr=%0d want 0 0", lap_cnt, ac_cnt); end
        $display("test_reset done: busy=%b active=%b", busy, active);
    endtask

    task automatic test_spawn_and_lap;
        begin_round(1'b0);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL start_busy: got %b want 1", busy); end
        goto(7);
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL pre_tick_active: got %b want 00", active); end
        goto(8);
        vectors++; if (active !== 2'b01 || bx(0) != 10 || by(0) != 20 || br(0) != 3) begin miscompares++;
            $display("FAIL spawn0: got act=%b (%0d,%0d) r%0d want 01 (10,20) r3", active, bx(0), by(0), br(0)); end
        goto(17);
        vectors++; if (bx(0) != 11 || by(0) != 20) begin miscompares++; $display("FAIL tick2_bug0: got (%0d,%0d) want (11,20)", bx(0), by(0)); end
        goto(32);
        vectors++; if (active !== 2'b11 || bx(1) != 10 || by(1) != 20 || br(1) != 3) begin miscompares++;
            $display("FAIL spawn1: got act=%b (%0d,%0d) r%0d want 11 (10,20) r3", active, bx(1), by(1), br(1)); end
        goto(33);
        vectors++; if (bx(0) != 13 || by(0) != 20 || bx(1) != 10) begin miscompares++;
            $display("FAIL tick4: got bug0 (%0d,%0d) bug1 x=%0d want (13,20) x=10", bx(0), by(0), bx(1)); end
        goto(41);
        vectors++; if (br(0) != 2 || bx(0) != 13 || by(0) != 20) begin miscompares++;
            $display("FAIL corner_turn: got (%0d,%0d) r%0d want (13,20) r2", bx(0), by(0), br(0)); end
        goto(57);
        vectors++; if (bx(0) != 13 || by(0) != 22 || br(0) != 2) begin miscompares++;
            $display("FAIL bottom_edge: got (%0d,%0d) r%0d want (13,22) r2", bx(0), by(0), br(0)); end
        goto(120);
        vectors++; if (lap_cnt != 0) begin miscompares++; $display("FAIL early_lap: got %0d want 0", lap_cnt); end
        goto(121);
        vectors++; if (lap_done !== 1'b1 || bx(0) != 10 || by(0) != 20 || br(0) != 3) begin miscompares++;
            $display("FAIL lap_complete: got lap=%b (%0d,%0d) r%0d want 1 (10,20) r3", lap_done, bx(0), by(0), br(0)); end
        goto(122);
        vectors++; if (lap_done !== 1'b0 || lap_cnt != 1) begin miscompares++;
            $display("FAIL lap_single: got lap=%b count=%0d want 0 1", lap_done, lap_cnt); end
        vectors++; if (bx(1) != 10 || by(1) != 22 || br(1) != 0) begin miscompares++;
            $display("FAIL bug1_pos: got (%0d,%0d) r%0d want (10,22) r0", bx(1), by(1), br(1)); end
        $display("test_spawn_and_lap done: laps=%0d", lap_cnt);
    endtask

    task automatic test_kill;
        goto(129);
        vectors++; if (bx(0) != 11) begin miscompares++; $display("FAIL lap2_bug0: got x=%0d want 11", bx(0)); end
        kill = 2'b10;
        goto(130);
        kill = 2'b00;
        vectors++; if (active !== 2'b01 || bx(1) != 10 || by(1) != 22 || br(1) != 0) begin miscompares++;
            $display("FAIL kill_in_slot: got act=%b (%0d,%0d) r%0d want 01 (10,22) r0", active, bx(1), by(1), br(1)); end
        goto(137);
        vectors++; if (bx(0) != 12 || by(1) != 22 || active !== 2'b01) begin miscompares++;
            $display("FAIL after_kill: got x0=%0d y1=%0d act=%b want 12 22 01", bx(0), by(1), active); end
        goto(140);
        kill = 2'b01;
        goto(141);
        kill = 2'b00;
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL kill0: got %b want 00", active); end
        goto(146);
        vectors++; if (ac_cnt != 0 || busy_drops != 0) begin miscompares++;
            $display("FAIL early_clear: got clr=%0d drops=%0d want 0 0", ac_cnt, busy_drops); end
        goto(147);
        vectors++; if (all_clear !== 1'b1) begin miscompares++; $display("FAIL all_clear: got %b want 1", all_clear); end
        goto(148);
        vectors++; if (all_clear !== 1'b0 || busy !== 1'b0 || ac_cnt != 1) begin miscompares++;
            $display("FAIL round_end: got clr=%b busy=%b count=%0d want 0 0 1", all_clear, busy, ac_cnt); end
        vectors++; if (bx(0) != 12 || by(0) != 20 || br(0) != 3) begin miscompares++;
            $display("FAIL frozen0: got (%0d,%0d) r%0d want (12,20) r3", bx(0), by(0), br(0)); end
        $display("test_kill done: clears=%0d", ac_cnt);
    endtask

    task automatic test_start_held;
        kill = 2'b11;
        begin_round(1'b1);
        vectors++; if (busy !== 1'b1) begin miscompares++; $display("FAIL held_busy: got %b want 1", busy); end
        goto(8);
        vectors++; if (active !== 2'b01 || bx(0) != 10 || br(0) != 3) begin miscompares++;
            $display("FAIL held_spawn0: got act=%b x=%0d r%0d want 01 10 r3", active, bx(0), br(0)); end
        goto(9);
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL spawn_kill0: got %b want 00", active); end
        goto(32);
        vectors++; if (active !== 2'b10 || bx(1) != 10 || by(1) != 20 || br(1) != 3) begin miscompares++;
            $display("FAIL held_spawn1: got act=%b (%0d,%0d) r%0d want 10 (10,20) r3", active, bx(1), by(1), br(1)); end
        goto(34);
        vectors++; if (busy_drops != 0 || ac_cnt != 0) begin miscompares++;
            $display("FAIL held_restart: got drops=%0d clr=%0d want 0 0", busy_drops, ac_cnt); end
        goto(35);
        vectors++; if (all_clear !== 1'b1 || busy !== 1'b0) begin miscompares++;
            $display("FAIL held_clear: got clr=%b busy=%b want 1 0", all_clear, busy); end
        goto(36);
        vectors++; if (busy !== 1'b1 || all_clear !== 1'b0) begin miscompares++;
            $display("FAIL new_round: got busy=%b clr=%b want 1 0", busy, all_clear); end
        goto(43);
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL new_pre_tick: got %b want 00", active); end
        goto(44);
        start = 1'b0;
        kill = 2'b00;
        vectors++; if (active !== 2'b01) begin miscompares++; $display("FAIL new_spawn: got %b want 01", active); end
        $display("test_start_held done: busy=%b", busy);
    endtask

    task automatic test_reset_mid_pass;
        goto(52);
        rst = 1'b1;
        lap_cnt = 0; ac_cnt = 0;
        goto(53);
        vectors++; if (busy !== 1'b0 || active !== 2'b00 || bx(0) != 10 || br(0) != 3) begin miscompares++;
            $display("FAIL mid_reset: got busy=%b act=%b x=%0d r%0d want 0 00 10 r3", busy, active, bx(0), br(0)); end
        vectors++; if (lap_done !== 1'b0 || all_clear !== 1'b0) begin miscompares++;
            $display("FAIL mid_reset_pulse: got lap=%b clr=%b want 0 0", lap_done, all_clear); end
        rst = 1'b0;
        goto(60);
        vectors++; if (lap_cnt != 0 || ac_cnt != 0 || busy !== 1'b0) begin miscompares++;
            $display("FAIL post_reset_idle: got lap=%0d clr=%0d busy=%b want 0 0 0", lap_cnt, ac_cnt, busy); end
        begin_round(1'b0);
        goto(7);
        vectors++; if (active !== 2'b00) begin miscompares++; $display("FAIL restart_pre: got %b want 00", active); end
        goto(8);
        vectors++; if (active !== 2'b01) begin miscompares++; $display("FAIL restart_spawn: got %b want 01", active); end
        $display("test_reset_mid_pass done: active=%b", active);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want completion");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_spawn_and_lap();
        test_kill();
        test_start_held();
        test_reset_mid_pass();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
